// File: rtl/butterfly_cla_pipe_if.sv
// Operand/result handshake bundle for butterfly_cla_pipe.
// The master drives operands and out_ready; the slave (the adder) returns in_ready and results.
interface butterfly_cla_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );
endinterface

// File: rtl/butterfly_cla_pipe.sv
// Skewed STAGES-deep add/sub pipeline built from rippled 4-bit carry-lookahead groups.
// Define BUTTERFLY_CLA_SAT_EN to saturate the sum to signed max/min on overflow.
module butterfly_cla_pipe #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   butterfly_cla_pipe_if.slave io_bus
);
   localparam int unsigned SW = WIDTH / STAGES;
   localparam int unsigned NG = SW / 4;

   // Returns {carry out, carry into bit 3, sum[3:0]}.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x | y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      return {c[4], c[3], x ^ y ^ c[3:0]};
   endfunction

   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_cy  [STAGES];
   logic             r_ovf;

   logic             w_adv;
   logic             w_vld_src [STAGES];
   logic [WIDTH-1:0] w_a_src   [STAGES];
   logic [WIDTH-1:0] w_b_src   [STAGES];
   logic [WIDTH-1:0] w_sum_nxt [STAGES];
   logic             w_cy_nxt  [STAGES];
   logic             w_c_msb;
   logic             w_ovf_nxt;
   logic             w_unused_tail;

   assign w_adv = !r_vld[STAGES-1] || io_bus.out_ready;

   always_comb begin : p_stages
      logic       c;
      logic [5:0] grp;
      int         p;
      c         = 1'b0;
      grp       = '0;
      p         = 0;
      w_c_msb   = 1'b0;
      w_ovf_nxt = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         p = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            // B is stored already inverted in sub mode so later stages need no mode bit.
            w_vld_src[k] = io_bus.in_valid;
            w_a_src[k]   = io_bus.a;
            w_b_src[k]   = io_bus.sub ? ~io_bus.b : io_bus.b;
            w_sum_nxt[k] = '0;
            c            = io_bus.sub | io_bus.c_in;
         end else begin
            w_vld_src[k] = r_vld[p];
            w_a_src[k]   = r_a[p];
            w_b_src[k]   = r_b[p];
            w_sum_nxt[k] = r_sum[p];
            c            = r_cy[p];
         end
         for (int g = 0; g < NG; g++) begin
            grp = cla4(w_a_src[k][k*SW + g*4 +: 4], w_b_src[k][k*SW + g*4 +: 4], c);
            w_sum_nxt[k][k*SW + g*4 +: 4] = grp[3:0];
            w_c_msb = grp[4];
            c       = grp[5];
         end
         w_cy_nxt[k] = c;
      end
      w_ovf_nxt = w_c_msb ^ w_cy_nxt[STAGES-1];
`ifdef BUTTERFLY_CLA_SAT_EN
      if (w_ovf_nxt) begin
         w_sum_nxt[STAGES-1] = w_a_src[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                          : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_cy[k]  <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vld_src[k];
            r_a[k]   <= w_a_src[k];
            r_b[k]   <= w_b_src[k];
            r_sum[k] <= w_sum_nxt[k];
            r_cy[k]  <= w_cy_nxt[k];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   // Operands are fully consumed by the last stage.
   assign w_unused_tail = ^{r_a[STAGES-1], r_b[STAGES-1]};

   assign io_bus.in_ready  = w_adv;
   assign io_bus.out_valid = r_vld[STAGES-1];
   assign io_bus.sum       = r_sum[STAGES-1];
   assign io_bus.c_out     = r_cy[STAGES-1];
   assign io_bus.ovf       = r_ovf;
endmodule

// File: tb/tb_butterfly_cla_pipe.sv
// Bench for butterfly_cla_pipe (WIDTH=16, STAGES=2): directed vectors, random traffic against an
// arithmetic model, back-to-back streaming with a stall, and asynchronous reset mid-flight.
module tb_butterfly_cla_pipe;
   localparam int unsigned W  = 16;
   localparam int unsigned S  = 2;
   localparam int unsigned RW = W + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] obs_q[$];

   butterfly_cla_pipe_if #(.WIDTH(W)) bus ();

   butterfly_cla_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Reference result {c_out, ovf, sum} from plain integer arithmetic.
   function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sub);
      longint ua, ub, sa, sb, sr, smax, smin;
      logic [W-1:0] s;
      logic co, ov;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      if (sub) begin
         s  = W'(ua - ub);
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         s  = W'(ua + ub + longint'(ci));
         co = ((ua + ub + longint'(ci)) >= (longint'(1) << W));
         sr = sa + sb + longint'(ci);
      end
      ov = (sr > smax) || (sr < smin);
`ifdef BUTTERFLY_CLA_SAT_EN
      if (ov) s = a[W-1] ? W'(smin) : W'(smax);
`endif
      return {co, ov, s};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
         if (bus.out_valid && bus.out_ready)
            obs_q.push_back({bus.c_out, bus.ovf, bus.sum});
      end
   end

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.c_in     = 1'b0;
      bus.sub      = 1'b0;
   endtask

   task automatic flush_queues();
      idle();
      bus.out_ready = 1'b1;
      repeat (S + 2) @(posedge clk);
      #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      idle();
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
      n_checks++;
      if ({bus.c_out, bus.ovf, bus.sum} !== '0)
         $display("FAIL rst_result: got %h want 0", {bus.c_out, bus.ovf, bus.sum});
      else n_pass++;
      // Release and present the first operand so it is taken on the very next rising edge.
      @(negedge clk);
      rst_n         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 16'h0001;
      bus.b         = 16'h0002;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      idle();
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0003)
         $display("FAIL first_accept: got valid=%b sum=%h want valid=1 sum=0003",
                  bus.out_valid, bus.sum);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[4], tb_v[4], ts[4];
      logic         tc[4], tsub[4], tco[4], tov[4];
      ta   = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
      tb_v = '{16'h0FF0, 16'h0001, 16'h0001, 16'h0007};
      tc   = '{1'b1, 1'b0, 1'b0, 1'b0};
      tsub = '{1'b0, 1'b0, 1'b0, 1'b1};
      ts   = '{16'h2225, 16'h0000, 16'h8000, 16'hFFFE};
`ifdef BUTTERFLY_CLA_SAT_EN
      ts[2] = 16'h7FFF;
`endif
      tco  = '{1'b0, 1'b1, 1'b0, 1'b0};
      tov  = '{1'b0, 1'b0, 1'b1, 1'b0};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b1;
         bus.a        = ta[i];
         bus.b        = tb_v[i];
         bus.c_in     = tc[i];
         bus.sub      = tsub[i];
         @(posedge clk);
         #1;
         idle();
         for (int j = 1; j < S; j++) begin
            n_checks++;
            if (bus.out_valid !== 1'b0)
               $display("FAIL dir%0d_early: got out_valid=%b want 0", i, bus.out_valid);
            else n_pass++;
            @(posedge clk);
            #1;
         end
         n_checks++;
         if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_valid: got %b want 1", i, bus.out_valid);
         else n_pass++;
         n_checks++;
         if (bus.sum !== ts[i]) $display("FAIL dir%0d_sum: got %h want %h", i, bus.sum, ts[i]);
         else n_pass++;
         n_checks++;
         if (bus.c_out !== tco[i]) $display("FAIL dir%0d_cout: got %b want %b", i, bus.c_out, tco[i]);
         else n_pass++;
         n_checks++;
         if (bus.ovf !== tov[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, bus.ovf, tov[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] corner[4];
      corner = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
      flush_queues();
      for (int i = 0; i < 120; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.a         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         bus.b         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         bus.c_in      = 1'($urandom_range(0, 1));
         bus.sub       = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      idle();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL rand_result[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] va[8], vb[8];
      logic         vc[8], vs[8];
      int           idx;
      for (int i = 0; i < 8; i++) begin
         va[i] = W'($urandom);
         vb[i] = W'($urandom);
         vc[i] = 1'($urandom_range(0, 1));
         vs[i] = 1'($urandom_range(0, 1));
      end
      flush_queues();
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         bus.in_valid  = 1'b1;
         bus.a         = va[idx];
         bus.b         = vb[idx];
         bus.c_in      = vc[idx];
         bus.sub       = vs[idx];
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         @(negedge clk);
         if (cyc >= 4 && cyc <= 6) begin
            // Third operand's result must sit frozen on the output for the whole stall.
            n_checks++;
            if (bus.in_ready !== 1'b0)
               $display("FAIL stall%0d_in_ready: got %b want 0", cyc, bus.in_ready);
            else n_pass++;
            n_checks++;
            if (bus.out_valid !== 1'b1)
               $display("FAIL stall%0d_out_valid: got %b want 1", cyc, bus.out_valid);
            else n_pass++;
            n_checks++;
            if ({bus.c_out, bus.ovf, bus.sum} !== model(va[2], vb[2], vc[2], vs[2]))
               $display("FAIL stall%0d_hold: got %h want %h", cyc,
                        {bus.c_out, bus.ovf, bus.sum}, model(va[2], vb[2], vc[2], vs[2]));
            else n_pass++;
         end
         if (bus.in_ready) idx++;
         @(posedge clk);
         #1;
      end
      idle();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 20 && obs_q.size() < 8; t++) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (exp_q.size() !== 8) $display("FAIL b2b_accepted: got %0d want 8", exp_q.size());
      else n_pass++;
      n_checks++;
      if (obs_q.size() !== 8) $display("FAIL b2b_count: got %0d want 8", obs_q.size());
      else n_pass++;
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== model(va[i], vb[i], vc[i], vs[i]))
            $display("FAIL b2b_result[%0d]: got %h want %h", i, obs_q[i],
                     model(va[i], vb[i], vc[i], vs[i]));
         else n_pass++;
      end
   endtask

   task automatic test_reset_midflight();
      flush_queues();
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      @(posedge clk);
      #1;
      bus.a = 16'h3333;
      bus.b = 16'h4444;
      @(posedge clk);
      #1;
      idle();
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.sum !== 16'h0000) $display("FAIL mid_async_sum: got %h want 0000", bus.sum);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b0)
            $display("FAIL mid_stale%0d: got out_valid=%b want 0", t, bus.out_valid);
         else n_pass++;
      end
      n_checks++;
      if (obs_q.size() !== 0) $display("FAIL mid_no_results: got %0d want 0", obs_q.size());
      else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      bus.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
